// File: rtl/fm_ddr_wr_master_pkg.sv
// rtl/fm_ddr_wr_master_pkg.sv - shared widths, FSM state type and burst sizing helper
//   CTRL_ADDR_WIDTH / DATA_WIDTH : DDR controller address and data widths
//   MAX_BURST_LEN                : largest burst the controller accepts (awlen is 4 bits)
//   DEF_ADDR_STEP                : default address increment per beat (column units)
//   wr_state_e                   : write-master FSM states
//   burst_awlen()                : awlen for the next burst given beats still to write
package fm_ddr_wr_master_pkg;

  localparam int CTRL_ADDR_WIDTH = 28;
  localparam int DATA_WIDTH      = 256;
  localparam int MAX_BURST_LEN   = 16;
  localparam int DEF_ADDR_STEP   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FIN
  } wr_state_e;

  // awlen = min(rem, max_len) - 1; rem==0 never reaches the bus, keep awlen at 0
  function automatic logic [3:0] burst_awlen(input logic [15:0] rem, input int max_len);
    if (rem == 16'd0) return 4'd0;
    if (rem >= 16'(max_len)) return 4'(max_len - 1);
    return 4'(rem - 16'd1);
  endfunction

endpackage

// File: rtl/fm_ddr_wr_master_if.sv
// rtl/fm_ddr_wr_master_if.sv - AXI write address/data channel bundle to the DDR controller
//   master modport : drives aw* / wdata / wstrb, samples awready / wready / wusero_last
//   slave modport  : the controller side of the same signals
interface fm_ddr_wr_master_if;
  import fm_ddr_wr_master_pkg::*;

  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
  logic [3:0]                 axi_awuser_id;
  logic [3:0]                 axi_awlen;
  logic                       axi_awvalid;
  logic                       axi_awready;
  logic [DATA_WIDTH-1:0]      axi_wdata;
  logic [DATA_WIDTH/8-1:0]    axi_wstrb;
  logic                       axi_wready;
  logic                       axi_wusero_last;

  modport master (
    output axi_awaddr, axi_awuser_id, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
    input  axi_awready, axi_wready, axi_wusero_last
  );

  modport slave (
    input  axi_awaddr, axi_awuser_id, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
    output axi_awready, axi_wready, axi_wusero_last
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO, DW x 2**AW, with occupancy count
//   clk, rstn           : clock, async active-low reset (pointers/count only)
//   push, push_data     : write; accepted when not full, or when full and popping
//   pop, pop_data       : pop_data is the head; pop on empty is ignored
//   count, full, empty  : occupancy status
module sync_fifo_fwft #(
  parameter int DW = 256,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // a pop frees the slot in the same cycle, so a full FIFO can still take a beat
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fm_ddr_wr_master.sv
// rtl/fm_ddr_wr_master.sv - buffers feature-map beats and writes them to DDR as AXI bursts
//   clk, rstn                      : core clock, async active-low reset
//   start, base_addr, total_beats  : job launch (ignored unless idle)
//   busy, done, err                : job status; err = sticky {wlast_mismatch, overflow}
//   data_in, data_valid_in         : incoming beats, pushed while data_ready
//   data_ready                     : FIFO can take a beat this cycle
//   axi                            : write address/data channel (master side)
module fm_ddr_wr_master
  import fm_ddr_wr_master_pkg::*;
#(
  parameter int BURST_LEN = MAX_BURST_LEN,
  parameter int ADDR_STEP = DEF_ADDR_STEP,
  parameter int FIFO_AW   = 5,
  parameter int AXI_ID    = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [CTRL_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]                total_beats,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_valid_in,
  output logic                       data_ready,
  fm_ddr_wr_master_if.master         axi
);

  wr_state_e                  state_q, state_d;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q;
  logic [15:0]                remaining_q;
  logic [3:0]                 awlen_q;
  logic [4:0]                 beat_cnt_q;
  logic                       awvalid_q;
  logic [1:0]                 err_q, err_d;

  logic [4:0]                 blen;
  logic [15:0]                rem_after;
  logic                       pop, is_last, last_pop, push, accept_start;
  logic [FIFO_AW:0]           fifo_count;
  logic                       fifo_full, fifo_empty;

  assign blen         = {1'b0, awlen_q} + 5'd1;
  assign rem_after    = remaining_q - 16'(blen);
  assign accept_start = (state_q == ST_IDLE) && start;
  // the controller cannot stall wready, so a burst only starts once fully buffered
  assign pop          = (state_q == ST_DATA) && axi.axi_wready && !fifo_empty;
  assign is_last      = (beat_cnt_q == {1'b0, awlen_q});
  assign last_pop     = pop && is_last;
  assign data_ready   = !fifo_full || pop;
  assign push         = data_valid_in && data_ready;

  sync_fifo_fwft #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (axi.axi_wdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign axi.axi_awaddr    = addr_q;
  assign axi.axi_awlen     = awlen_q;
  assign axi.axi_awvalid   = awvalid_q;
  assign axi.axi_awuser_id = 4'(AXI_ID);
  assign axi.axi_wstrb     = '1;
  assign err               = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = (total_beats == 16'd0) ? ST_FIN : ST_ADDR;
      ST_ADDR: begin
        busy = 1'b1;
        if (awvalid_q && axi.axi_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        busy = 1'b1;
        if (last_pop) state_d = (rem_after == 16'd0) ? ST_FIN : ST_ADDR;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (accept_start) err_d = 2'b00;
    if (data_valid_in && !data_ready) err_d[0] = 1'b1;
    // own beat count stays authoritative; a misplaced wusero_last is only flagged
    if (pop && (axi.axi_wusero_last != is_last)) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      remaining_q <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      awvalid_q   <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      err_q <= err_d;
      if (accept_start) begin
        addr_q      <= base_addr;
        remaining_q <= total_beats;
        awlen_q     <= burst_awlen(total_beats, BURST_LEN);
        beat_cnt_q  <= '0;
      end
      if (state_q == ST_ADDR) begin
        if (!awvalid_q) begin
          if (fifo_count >= (FIFO_AW+1)'(blen)) awvalid_q <= 1'b1;
        end else if (axi.axi_awready) begin
          awvalid_q <= 1'b0;
        end
      end
      if (pop) begin
        if (is_last) begin
          beat_cnt_q  <= '0;
          addr_q      <= addr_q + (CTRL_ADDR_WIDTH'(blen) * CTRL_ADDR_WIDTH'(ADDR_STEP));
          remaining_q <= rem_after;
          if (rem_after != 16'd0) awlen_q <= burst_awlen(rem_after, BURST_LEN);
        end else begin
          beat_cnt_q <= beat_cnt_q + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_ddr_wr_master.sv
// tb/tb_fm_ddr_wr_master.sv - directed self-checking bench for fm_ddr_wr_master
module tb_fm_ddr_wr_master;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [27:0]  base_addr;
  logic [15:0]  total_beats;
  logic         busy, done, data_ready, data_valid_in;
  logic [1:0]   err;
  logic [255:0] data_in;

  int errors = 0;
  int checks = 0;

  logic [27:0]  aw_addr_q[$];
  logic [3:0]   aw_len_q[$];
  logic [255:0] wd_q[$];
  int done_cnt, stall_bad, stall_cycles, pushed_cnt, pushed_at_awv;

  fm_ddr_wr_master_if axi_if ();

  fm_ddr_wr_master dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .base_addr     (base_addr),
    .total_beats   (total_beats),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .data_ready    (data_ready),
    .axi           (axi_if)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] beat(input int t);
    logic [31:0] v;
    v = t;
    return {8{v ^ 32'hA5C3_0000}};
  endfunction

  task automatic pulse_start(input logic [27:0] b, input logic [15:0] t);
    base_addr = b; total_beats = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // pushes n beats tagged tag0.. only while data_ready, with gap idle cycles between beats
  task automatic feed(input int n, input int tag0, input int gap, input int budget);
    int i = 0;
    int g = 0;
    for (int c = 0; c < budget && i < n; c++) begin
      @(posedge clk); #2;
      data_valid_in = 1'b0;
      if (g > 0) g--;
      else if (data_ready) begin
        data_valid_in = 1'b1; data_in = beat(tag0 + i); i++; pushed_cnt++; g = gap;
      end
    end
    @(posedge clk); #2;
    data_valid_in = 1'b0;
  endtask

  // controller model: accepts aw after aw_delay cycles, then drives wready for awlen+1 beats
  task automatic serve(input int budget, input int aw_delay, input bit bad_last);
    int beats_left = 0;
    int wait_cnt = 0;
    int post = 0;
    bit seen = 0;
    bit first = 0;
    logic [27:0] sa;
    logic [3:0]  sl;
    aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete();
    done_cnt = 0; stall_bad = 0; stall_cycles = 0; pushed_at_awv = -1;
    sa = '0; sl = '0;
    for (int c = 0; c < budget; c++) begin
      axi_if.axi_awready = 1'b0; axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
      if (axi_if.axi_awvalid) begin
        if (!first) begin first = 1; pushed_at_awv = pushed_cnt; end
        if (seen && (axi_if.axi_awaddr !== sa || axi_if.axi_awlen !== sl)) stall_bad++;
        if (!seen) begin seen = 1; sa = axi_if.axi_awaddr; sl = axi_if.axi_awlen; end
      end
      if (beats_left > 0) begin
        axi_if.axi_wready = 1'b1;
        axi_if.axi_wusero_last = bad_last ? 1'b0 : (beats_left == 1);
        wd_q.push_back(axi_if.axi_wdata);
        beats_left--;
      end else if (axi_if.axi_awvalid) begin
        if (wait_cnt >= aw_delay) begin
          axi_if.axi_awready = 1'b1;
          aw_addr_q.push_back(axi_if.axi_awaddr);
          aw_len_q.push_back(axi_if.axi_awlen);
          beats_left = int'(axi_if.axi_awlen) + 1;
          seen = 0; wait_cnt = 0;
        end else begin
          wait_cnt++; stall_cycles++;
        end
      end
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      if (post >= 4) break;
    end
    axi_if.axi_awready = 1'b0; axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err actual=%b required=00", err); end
    checks++; if (axi_if.axi_awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid actual=%b required=0", axi_if.axi_awvalid); end
    checks++; if (axi_if.axi_awaddr !== 28'h0) begin errors++; $display("FAIL reset_awaddr actual=%h required=0", axi_if.axi_awaddr); end
    checks++; if (axi_if.axi_awlen !== 4'h0) begin errors++; $display("FAIL reset_awlen actual=%h required=0", axi_if.axi_awlen); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready actual=%b required=1", data_ready); end
    checks++; if (axi_if.axi_wstrb !== {32{1'b1}}) begin errors++; $display("FAIL reset_wstrb actual=%h required=all ones", axi_if.axi_wstrb); end
    checks++; if (axi_if.axi_awuser_id !== 4'h0) begin errors++; $display("FAIL reset_awuser_id actual=%h required=0", axi_if.axi_awuser_id); end
  endtask

  task automatic test_single_burst();
    feed(16, 0, 0, 100);
    pulse_start(28'h100, 16'd16);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy actual=%b required=1", busy); end
    checks++; if (axi_if.axi_awvalid !== 1'b0) begin errors++; $display("FAIL single_aw_latency actual=%b required=0", axi_if.axi_awvalid); end
    serve(100, 0, 0);
    checks++; if (aw_addr_q.size() !== 1) begin errors++; $display("FAIL single_bursts actual=%0d required=1", aw_addr_q.size()); end
    else begin
      checks++; if (aw_addr_q[0] !== 28'h100) begin errors++; $display("FAIL single_awaddr actual=%h required=100", aw_addr_q[0]); end
      checks++; if (aw_len_q[0] !== 4'd15) begin errors++; $display("FAIL single_awlen actual=%0d required=15", aw_len_q[0]); end
    end
    checks++; if (wd_q.size() !== 16) begin errors++; $display("FAIL single_beats actual=%0d required=16", wd_q.size()); end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== beat(i)) begin errors++; $display("FAIL single_data[%0d] actual=%h required=%h", i, wd_q[i][31:0], beat(i) & 256'hFFFF_FFFF); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done actual=%0d required=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end actual=%b required=0", busy); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL single_err actual=%b required=00", err); end
  endtask

  task automatic test_multi_burst();
    logic [27:0] ea [3];
    logic [3:0]  el [3];
    ea[0] = 28'h100; ea[1] = 28'h180; ea[2] = 28'h200;
    el[0] = 4'd15;   el[1] = 4'd15;   el[2] = 4'd7;
    pulse_start(28'h100, 16'd40);
    fork
      feed(40, 100, 0, 400);
      serve(400, 0, 0);
    join
    checks++; if (aw_addr_q.size() !== 3) begin errors++; $display("FAIL multi_bursts actual=%0d required=3", aw_addr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (aw_addr_q[i] !== ea[i]) begin errors++; $display("FAIL multi_awaddr[%0d] actual=%h required=%h", i, aw_addr_q[i], ea[i]); end
      checks++; if (aw_len_q[i] !== el[i]) begin errors++; $display("FAIL multi_awlen[%0d] actual=%0d required=%0d", i, aw_len_q[i], el[i]); end
    end
    checks++; if (wd_q.size() !== 40) begin errors++; $display("FAIL multi_beats actual=%0d required=40", wd_q.size()); end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== beat(100 + i)) begin errors++; $display("FAIL multi_data[%0d] actual=%h required=%h", i, wd_q[i][31:0], beat(100 + i) & 256'hFFFF_FFFF); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL multi_done actual=%0d required=1", done_cnt); end
  endtask

  task automatic test_aw_stall();
    feed(16, 200, 0, 100);
    pulse_start(28'h0ABC, 16'd16);
    serve(100, 5, 0);
    checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL stall_cycles actual=%0d required=5", stall_cycles); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_aw_stable actual=%0d changes required=0", stall_bad); end
    checks++; if (aw_addr_q.size() !== 1) begin errors++; $display("FAIL stall_bursts actual=%0d required=1", aw_addr_q.size()); end
    else begin
      checks++; if (aw_addr_q[0] !== 28'h0ABC) begin errors++; $display("FAIL stall_awaddr actual=%h required=0abc", aw_addr_q[0]); end
      checks++; if (aw_len_q[0] !== 4'd15) begin errors++; $display("FAIL stall_awlen actual=%0d required=15", aw_len_q[0]); end
    end
    checks++; if (wd_q.size() !== 16) begin errors++; $display("FAIL stall_beats actual=%0d required=16", wd_q.size()); end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== beat(200 + i)) begin errors++; $display("FAIL stall_data[%0d] actual=%h required=%h", i, wd_q[i][31:0], beat(200 + i) & 256'hFFFF_FFFF); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done actual=%0d required=1", done_cnt); end
  endtask

  task automatic test_trickle();
    pushed_cnt = 0;
    pulse_start(28'h300, 16'd16);
    fork
      feed(16, 400, 3, 200);
      serve(200, 0, 0);
    join
    checks++; if (pushed_at_awv !== 16) begin errors++; $display("FAIL trickle_awvalid_at actual=%0d beats required=16", pushed_at_awv); end
    checks++; if (wd_q.size() !== 16) begin errors++; $display("FAIL trickle_beats actual=%0d required=16", wd_q.size()); end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== beat(400 + i)) begin errors++; $display("FAIL trickle_data[%0d] actual=%h required=%h", i, wd_q[i][31:0], beat(400 + i) & 256'hFFFF_FFFF); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL trickle_done actual=%0d required=1", done_cnt); end
  endtask

  task automatic test_wlast_mismatch();
    feed(4, 500, 0, 50);
    pulse_start(28'h20, 16'd4);
    serve(60, 0, 1);
    checks++; if (aw_len_q.size() !== 1 || aw_len_q[0] !== 4'd3) begin errors++; $display("FAIL wlast_awlen actual=%0d bursts required=1 burst awlen 3", aw_len_q.size()); end
    checks++; if (wd_q.size() !== 4) begin errors++; $display("FAIL wlast_beats actual=%0d required=4", wd_q.size()); end
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL wlast_err actual=%b required=10", err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wlast_done actual=%0d required=1", done_cnt); end
  endtask

  task automatic test_zero_beats();
    int awv = 0;
    pulse_start(28'h77, 16'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done actual=%b required=1", done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL zero_err_cleared actual=%b required=00", err); end
    for (int c = 0; c < 6; c++) begin
      if (axi_if.axi_awvalid) awv++;
      @(posedge clk); #1;
      if (c == 0) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width actual=%b required=0", done); end
      end
    end
    checks++; if (awv !== 0) begin errors++; $display("FAIL zero_awvalid actual=%0d cycles required=0", awv); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 33; i++) begin
      data_valid_in = 1'b1; data_in = beat(700 + i);
      @(posedge clk); #1;
    end
    data_valid_in = 1'b0;
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL ovf_err actual=%b required=01", err); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL ovf_data_ready actual=%b required=0", data_ready); end
    pulse_start(28'h40, 16'd32);
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL ovf_err_cleared actual=%b required=00", err); end
    serve(200, 0, 0);
    checks++; if (aw_addr_q.size() !== 2) begin errors++; $display("FAIL ovf_bursts actual=%0d required=2", aw_addr_q.size()); end
    else begin
      checks++; if (aw_addr_q[1] !== 28'h0C0) begin errors++; $display("FAIL ovf_awaddr1 actual=%h required=0c0", aw_addr_q[1]); end
    end
    checks++; if (wd_q.size() !== 32) begin errors++; $display("FAIL ovf_beats actual=%0d required=32", wd_q.size()); end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== beat(700 + i)) begin errors++; $display("FAIL ovf_data[%0d] actual=%h required=%h", i, wd_q[i][31:0], beat(700 + i) & 256'hFFFF_FFFF); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ovf_done actual=%0d required=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int awv = 0;
    feed(16, 900, 0, 100);
    pulse_start(28'h300, 16'd16);
    for (int c = 0; c < 20 && !axi_if.axi_awvalid; c++) begin @(posedge clk); #1; end
    checks++; if (axi_if.axi_awvalid !== 1'b1) begin errors++; $display("FAIL rst_awvalid_pre actual=%b required=1", axi_if.axi_awvalid); end
    axi_if.axi_awready = 1'b1;
    @(posedge clk); #1;
    axi_if.axi_awready = 1'b0; axi_if.axi_wready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #2;
    axi_if.axi_wready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy actual=%b required=0", busy); end
    checks++; if (axi_if.axi_awaddr !== 28'h0) begin errors++; $display("FAIL rst_awaddr actual=%h required=0", axi_if.axi_awaddr); end
    checks++; if (axi_if.axi_awlen !== 4'h0) begin errors++; $display("FAIL rst_awlen actual=%h required=0", axi_if.axi_awlen); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_data_ready actual=%b required=1", data_ready); end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    pulse_start(28'h10, 16'd1);
    for (int c = 0; c < 10; c++) begin
      if (axi_if.axi_awvalid) awv++;
      @(posedge clk); #1;
    end
    checks++; if (awv !== 0) begin errors++; $display("FAIL rst_fifo_empty actual=%0d awvalid cycles required=0", awv); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_waiting_busy actual=%b required=1", busy); end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; total_beats = '0;
    data_in = '0; data_valid_in = 1'b0; pushed_cnt = 0;
    axi_if.axi_awready = 1'b0; axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_aw_stall();
    test_trickle();
    test_wlast_mismatch();
    test_zero_beats();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
